reg_host_master: RTL and testbench

REG_HOST_MASTER -- requirements
Module: reg_host_master

---
 rtl/reg_host_master_if.sv | 30 +++
 rtl/reg_host_master.sv | 179 +++++++++++++++++
 tb/tb_reg_host_master.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_host_master_if.sv
// Host command/response channel plus the register-bus pins between the
// register host master and the register file it drives.
interface reg_host_master_if;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 16;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;
  logic                rsp_valid;
  logic [2*DATA_W-1:0] rsp_data;
  logic                rsp_err;
  logic                CSB;
  logic                WRB;
  logic [ADDR_W:0]     CA;
  logic [DATA_W-1:0]   CD_in;
  logic [DATA_W-1:0]   CD_out;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, CD_out,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, CSB, WRB, CA, CD_in
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, CD_out,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, CSB, WRB, CA, CD_in
  );
endinterface

// File: rtl/reg_host_master.sv
// Register-bus host master: turns host write/read/RMON-counter commands into
// one-clock CSB bus cycles and returns a single-cycle response.
module reg_host_master #(
  parameter int unsigned POLL_TIMEOUT = 255
) (
  input  logic              Clk_reg,
  input  logic              Reset_n,
  reg_host_master_if.master bus
);

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 16;
  localparam logic [ADDR_W-1:0] W_ADDR  = 7'd28;
  localparam logic [ADDR_W-1:0] W_APPLY = 7'd29;
  localparam logic [ADDR_W-1:0] W_GRANT = 7'd30;
  localparam logic [ADDR_W-1:0] W_LO    = 7'd31;
  localparam logic [ADDR_W-1:0] W_HI    = 7'd32;
  localparam logic [8:0]        TIMEOUT = 9'(POLL_TIMEOUT);

  typedef enum logic [3:0] {
    IDLE, WR, RD, RD_CAP, RM_ADDR, RM_APPLY, RM_POLL, RM_POLL_CAP,
    RM_LO, RM_LO_CAP, RM_HI, RM_HI_CAP, RM_CLR, RESP
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  state_t              state_q, state_d;
  cmd_t                cmd_q, cmd_d;
  logic [7:0]          poll_q, poll_d;
  logic [8:0]          poll_inc;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   lo_q, lo_d, hi_q, hi_d;
  logic                ready_q, ready_d;
  logic                csb_q, csb_d, wrb_q, wrb_d;
  logic [ADDR_W:0]     ca_q, ca_d;
  logic [DATA_W-1:0]   cdin_q, cdin_d;
  logic                rvalid_q, rvalid_d, rerr_q, rerr_d;
  logic [2*DATA_W-1:0] rdata_q, rdata_d;

  // Next state, then every registered output derived from the state being entered.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    poll_d   = poll_q;
    err_d    = err_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    poll_inc = 9'(poll_q) + 9'd1;
    csb_d    = 1'b1;
    wrb_d    = 1'b1;
    ca_d     = '0;
    cdin_d   = '0;
    rvalid_d = 1'b0;
    rerr_d   = 1'b0;
    rdata_d  = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid && ready_q) begin
          cmd_d  = '{addr: bus.cmd_addr, wdata: bus.cmd_wdata};
          poll_d = '0;
          err_d  = 1'b0;
          unique case (bus.cmd_op)
            2'b00:   state_d = WR;
            2'b01:   state_d = RD;
            2'b10:   state_d = RM_ADDR;
            default: state_d = RESP;
          endcase
        end
      end
      WR:        state_d = RESP;
      RD:        state_d = RD_CAP;
      RD_CAP:    state_d = RESP;
      RM_ADDR:   state_d = RM_APPLY;
      RM_APPLY:  state_d = RM_POLL;
      RM_POLL:   state_d = RM_POLL_CAP;
      RM_POLL_CAP: begin
        if (bus.CD_out[0]) begin
          state_d = RM_LO;
        end else begin
          // Saturating count; a timeout still clears the apply bit before responding.
          if (poll_q != 8'hFF) poll_d = poll_inc[7:0];
          if (poll_inc >= TIMEOUT) begin
            err_d   = 1'b1;
            state_d = RM_CLR;
          end else begin
            state_d = RM_POLL;
          end
        end
      end
      RM_LO:     state_d = RM_LO_CAP;
      RM_LO_CAP: begin
        lo_d    = bus.CD_out;
        state_d = RM_HI;
      end
      RM_HI:     state_d = RM_HI_CAP;
      RM_HI_CAP: begin
        hi_d    = bus.CD_out;
        state_d = RM_CLR;
      end
      RM_CLR:    state_d = RESP;
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    unique case (state_d)
      WR:       begin csb_d = 1'b0; wrb_d = 1'b0; ca_d = {cmd_d.addr, 1'b0}; cdin_d = cmd_d.wdata; end
      RD:       begin csb_d = 1'b0; ca_d = {cmd_d.addr, 1'b0}; end
      RM_ADDR:  begin csb_d = 1'b0; wrb_d = 1'b0; ca_d = {W_ADDR, 1'b0}; cdin_d = {10'h0, cmd_d.addr[5:0]}; end
      RM_APPLY: begin csb_d = 1'b0; wrb_d = 1'b0; ca_d = {W_APPLY, 1'b0}; cdin_d = 16'd1; end
      RM_POLL:  begin csb_d = 1'b0; ca_d = {W_GRANT, 1'b0}; end
      RM_LO:    begin csb_d = 1'b0; ca_d = {W_LO, 1'b0}; end
      RM_HI:    begin csb_d = 1'b0; ca_d = {W_HI, 1'b0}; end
      RM_CLR:   begin csb_d = 1'b0; wrb_d = 1'b0; ca_d = {W_APPLY, 1'b0}; end
      RESP: begin
        rvalid_d = 1'b1;
        if (state_q == IDLE) begin
          rerr_d = 1'b1;
        end else if (state_q == RD_CAP) begin
          rdata_d = {16'h0, bus.CD_out};
        end else if (state_q == RM_CLR) begin
          rerr_d  = err_q;
          rdata_d = err_q ? '0 : {hi_q, lo_q};
        end
      end
      default: ;
    endcase

    ready_d = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge Clk_reg or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      poll_q   <= '0;
      err_q    <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
      ready_q  <= 1'b0;
      csb_q    <= 1'b1;
      wrb_q    <= 1'b1;
      ca_q     <= '0;
      cdin_q   <= '0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      poll_q   <= poll_d;
      err_q    <= err_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      ready_q  <= ready_d;
      csb_q    <= csb_d;
      wrb_q    <= wrb_d;
      ca_q     <= ca_d;
      cdin_q   <= cdin_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.CSB       = csb_q;
  assign bus.WRB       = wrb_q;
  assign bus.CA        = ca_q;
  assign bus.CD_in     = cdin_q;
  assign bus.rsp_valid = rvalid_q;
  assign bus.rsp_err   = rerr_q;
  assign bus.rsp_data  = rdata_q;

endmodule

// File: tb/tb_reg_host_master.sv
// Bench for reg_host_master: register-file slave with RMON grant/counters,
// and a transaction-level model predicting bus ops, latency and responses.
module tb_reg_host_master;
  localparam int unsigned TMO = 3;

  logic Clk_reg = 1'b0;
  logic Reset_n = 1'b1;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 Clk_reg = ~Clk_reg;

  reg_host_master_if bus ();
  reg_host_master #(.POLL_TIMEOUT(TMO)) dut (.Clk_reg(Clk_reg), .Reset_n(Reset_n), .bus(bus));

  typedef struct packed {
    logic        wrb;
    logic [7:0]  ca;
    logic [15:0] d;
  } op_t;

  logic [15:0] smem [128];
  logic [31:0] rmon [64];
  int          poll_seen;
  int          grant_after = 0;
  logic [15:0] mmem [128];
  op_t         seen_q [$];

  // Register-file slave: read data appears one edge after the read bus cycle.
  always @(posedge Clk_reg or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 128; i++) smem[i] <= 16'h0;
      smem[26]   <= 16'h2710;
      bus.CD_out <= 16'h0;
      poll_seen  <= 0;
    end else if (!bus.CSB) begin
      if (!bus.WRB) begin
        smem[bus.CA[7:1]] <= bus.CD_in;
        if (bus.CA[7:1] == 7'd29) poll_seen <= 0;
      end else begin
        case (bus.CA[7:1])
          7'd30: begin
            bus.CD_out <= (grant_after > 0 && poll_seen + 1 >= grant_after) ? 16'd1 : 16'd0;
            poll_seen  <= poll_seen + 1;
          end
          7'd31:   bus.CD_out <= rmon[smem[28][5:0]][15:0];
          7'd32:   bus.CD_out <= rmon[smem[28][5:0]][31:16];
          default: bus.CD_out <= smem[bus.CA[7:1]];
        endcase
      end
    end
  end

  always @(negedge Clk_reg)
    if (Reset_n && bus.CSB === 1'b0)
      seen_q.push_back(op_t'({bus.WRB, bus.CA, bus.WRB ? 16'h0 : bus.CD_in}));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic op_t mk(input logic w, input logic [6:0] idx, input logic [15:0] d);
    return op_t'({w, idx, 1'b0, w ? 16'h0 : d});
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 128; i++) mmem[i] = 16'h0;
    mmem[26] = 16'h2710;
  endtask

  task automatic wait_accept();
    int w = 0;
    while (bus.cmd_ready !== 1'b1 && w < 20) begin @(negedge Clk_reg); w++; end
    chk("accept_wait", 32'(w < 20), 32'd1);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 600) begin @(negedge Clk_reg); lat++; end
  endtask

  // One command through the model and the DUT; grant = poll on which the slave grants (0 = never).
  task automatic run_cmd(input logic [1:0] op, input logic [6:0] addr, input logic [15:0] wd,
                         input int grant, input string tag);
    op_t         exp_q [$];
    int          exp_lat, lat, n;
    logic [31:0] exp_data;
    logic        exp_err;
    bit          granted;
    exp_data = 32'h0; exp_err = 1'b0;
    case (op)
      2'b00: begin exp_q.push_back(mk(1'b0, addr, wd)); exp_lat = 2; mmem[addr] = wd; end
      2'b01: begin exp_q.push_back(mk(1'b1, addr, 16'h0)); exp_lat = 3; exp_data = {16'h0, mmem[addr]}; end
      2'b10: begin
        granted = (grant >= 1 && grant <= int'(TMO));
        n = granted ? grant : int'(TMO);
        exp_q.push_back(mk(1'b0, 7'd28, {10'h0, addr[5:0]}));
        exp_q.push_back(mk(1'b0, 7'd29, 16'd1));
        for (int i = 0; i < n; i++) exp_q.push_back(mk(1'b1, 7'd30, 16'h0));
        if (granted) begin
          exp_q.push_back(mk(1'b1, 7'd31, 16'h0));
          exp_q.push_back(mk(1'b1, 7'd32, 16'h0));
          exp_lat = 8 + 2 * n; exp_data = rmon[addr[5:0]];
        end else begin
          exp_lat = 4 + 2 * n; exp_err = 1'b1;
        end
        exp_q.push_back(mk(1'b0, 7'd29, 16'd0));
      end
      default: begin exp_lat = 1; exp_err = 1'b1; end
    endcase

    grant_after = grant;
    seen_q.delete();
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = addr; bus.cmd_wdata = wd;
    wait_accept();
    @(negedge Clk_reg);
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'($urandom);
    bus.cmd_addr  = 7'($urandom);
    bus.cmd_wdata = 16'($urandom);
    wait_rsp(lat);
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".rsp_data"}, bus.rsp_data, exp_data);
    chk({tag, ".rsp_err"}, 32'(bus.rsp_err), 32'(exp_err));
    chk({tag, ".csb_at_rsp"}, 32'(bus.CSB), 32'd1);
    chk({tag, ".bus_ops"}, 32'(seen_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++)
      chk($sformatf("%s.op%0d", tag, i), 32'(seen_q[i]), 32'(exp_q[i]));
    @(negedge Clk_reg);
    chk({tag, ".pulse_end"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, ".ready_after"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    int          lat, w;
    logic [1:0]  op;
    logic [6:0]  addr;

    for (int i = 0; i < 64; i++) rmon[i] = $urandom;
    rmon[5] = 32'hDEAD_BEEF;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_addr = 7'h0; bus.cmd_wdata = 16'h0;
    model_reset();

    // Reset values
    #2 Reset_n = 1'b0;
    repeat (2) @(negedge Clk_reg);
    chk("rst.csb", 32'(bus.CSB), 32'd1);
    chk("rst.wrb", 32'(bus.WRB), 32'd1);
    chk("rst.ca", 32'(bus.CA), 32'd0);
    chk("rst.cd_in", 32'(bus.CD_in), 32'd0);
    chk("rst.rsp", {29'h0, bus.rsp_valid, bus.rsp_err, 1'b0}, 32'd0);
    chk("rst.rsp_data", bus.rsp_data, 32'd0);
    chk("rst.ready", 32'(bus.cmd_ready), 32'd0);
    Reset_n = 1'b1;
    @(negedge Clk_reg);
    chk("rst.ready_first_edge", 32'(bus.cmd_ready), 32'd1);

    // Directed cases
    run_cmd(2'b01, 7'd26, 16'h0, 0, "rd26");
    run_cmd(2'b00, 7'd4, 16'h0012, 0, "wr4");
    chk("wr4.slave", 32'(smem[4]), 32'h12);
    run_cmd(2'b01, 7'd4, 16'h0, 0, "rd4");
    run_cmd(2'b10, 7'd5, 16'h0, 1, "rmon_g1");
    run_cmd(2'b10, 7'd5, 16'h0, 0, "rmon_timeout");
    run_cmd(2'b10, 7'd9, 16'h0, 2, "rmon_g2");
    run_cmd(2'b10, 7'd70, 16'h0, 3, "rmon_g3");
    run_cmd(2'b11, 7'd3, 16'hFFFF, 0, "reserved");

    // Back-to-back with cmd_valid held high
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b00; bus.cmd_addr = 7'd10; bus.cmd_wdata = 16'hA5C3;
    wait_accept();
    @(negedge Clk_reg);
    bus.cmd_op = 2'b01; bus.cmd_addr = 7'd10; bus.cmd_wdata = 16'h0;
    wait_rsp(lat);
    chk("b2b.first_lat", 32'(lat), 32'd2);
    mmem[10] = 16'hA5C3;
    @(negedge Clk_reg);
    chk("b2b.ready_gap", 32'(bus.cmd_ready), 32'd1);
    chk("b2b.csb_gap", 32'(bus.CSB), 32'd1);
    @(negedge Clk_reg);
    bus.cmd_valid = 1'b0;
    chk("b2b.second_cycle", {23'h0, bus.CSB, bus.CA}, {23'h0, 1'b0, 8'h14});
    wait_rsp(lat);
    chk("b2b.second_lat", 32'(lat), 32'd3);
    chk("b2b.second_data", bus.rsp_data, {16'h0, mmem[10]});
    @(negedge Clk_reg);

    // Reset pulsed while polling
    grant_after = 0;
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b10; bus.cmd_addr = 7'd7;
    wait_accept();
    @(negedge Clk_reg);
    bus.cmd_valid = 1'b0;
    w = 0;
    while (!(bus.CSB === 1'b0 && bus.CA === 8'h3C) && w < 20) begin @(negedge Clk_reg); w++; end
    chk("rpoll.reach", 32'(w < 20), 32'd1);
    Reset_n = 1'b0;
    #1;
    chk("rpoll.csb", 32'(bus.CSB), 32'd1);
    chk("rpoll.bus", {15'h0, bus.WRB, bus.CA, 8'h0}, {15'h0, 1'b1, 8'h0, 8'h0});
    chk("rpoll.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    repeat (2) @(negedge Clk_reg);
    Reset_n = 1'b1;
    model_reset();
    w = 0;
    for (int i = 0; i < 4; i++) begin @(negedge Clk_reg); if (bus.rsp_valid !== 1'b0) w++; end
    chk("rpoll.no_rsp", 32'(w), 32'd0);
    chk("rpoll.ready", 32'(bus.cmd_ready), 32'd1);
    run_cmd(2'b01, 7'd26, 16'h0, 0, "rd26_after_rst");

    // Randomized commands
    for (int k = 0; k < 40; k++) begin
      op   = 2'($urandom);
      addr = (op == 2'b10) ? 7'($urandom) : 7'($urandom_range(0, 27));
      run_cmd(op, addr, 16'($urandom), int'($urandom_range(0, TMO + 1)), $sformatf("rnd%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
